// File: rtl/cmp_pkg.sv
// Shared types for the magnitude-comparator family: debounce FSM states and
// the legal range of the debounce length.
package cmp_pkg;

    typedef enum logic [1:0] {
        BELOW     = 2'd0,
        ARMING    = 2'd1,
        ABOVE     = 2'd2,
        DISARMING = 2'd3
    } state_t;

    localparam int DEBOUNCE_MIN = 1;
    localparam int DEBOUNCE_MAX = 255;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// A synchronous clear takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cmp_debounce_monitor.sv
// Debounces one-hot comparator flags into a hysteretic "above threshold" level,
// pulses rise/fall on each committed change and counts rising events.
module cmp_debounce_monitor
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic             above,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] event_count,
    output logic             flag_err
);

    localparam int RUN_W = $clog2(DEBOUNCE + 1);

    if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_debounce
        $error("cmp_debounce_monitor: DEBOUNCE out of range");
    end

    state_t           state_q, state_nxt;
    logic [RUN_W-1:0] run_q, run_nxt;
    logic [RUN_W-1:0] run_inc;
    logic             legal;
    logic             rise_nxt, fall_nxt, err_set;

    assign legal   = $onehot({a_gt_b, a_lt_b, a_eq_b});
    assign run_inc = run_q + 1'b1;

    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        err_set   = 1'b0;
        if (in_valid) begin
            if (!legal) begin
                // Illegal flags leave any pending run untouched.
                err_set = 1'b1;
            end else begin
                unique case (state_q)
                    BELOW: begin
                        run_nxt = '0;
                        if (a_gt_b) begin
                            if (DEBOUNCE == 1) begin
                                state_nxt = ABOVE;
                                rise_nxt  = 1'b1;
                            end else begin
                                state_nxt = ARMING;
                                run_nxt   = RUN_W'(1);
                            end
                        end
                    end
                    ARMING: begin
                        run_nxt = '0;
                        if (a_gt_b) begin
                            if (run_inc == RUN_W'(DEBOUNCE)) begin
                                state_nxt = ABOVE;
                                rise_nxt  = 1'b1;
                            end else begin
                                run_nxt = run_inc;
                            end
                        end else begin
                            state_nxt = BELOW;
                        end
                    end
                    ABOVE: begin
                        run_nxt = '0;
                        if (a_lt_b) begin
                            if (DEBOUNCE == 1) begin
                                state_nxt = BELOW;
                                fall_nxt  = 1'b1;
                            end else begin
                                state_nxt = DISARMING;
                                run_nxt   = RUN_W'(1);
                            end
                        end
                    end
                    DISARMING: begin
                        run_nxt = '0;
                        if (a_lt_b) begin
                            if (run_inc == RUN_W'(DEBOUNCE)) begin
                                state_nxt = BELOW;
                                fall_nxt  = 1'b1;
                            end else begin
                                run_nxt = run_inc;
                            end
                        end else begin
                            state_nxt = ABOVE;
                        end
                    end
                    default: begin
                        state_nxt = BELOW;
                        run_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BELOW;
            run_q   <= '0;
            above   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            run_q   <= run_nxt;
            above   <= (state_nxt == ABOVE) || (state_nxt == DISARMING);
            rise    <= rise_nxt;
            fall    <= fall_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_err <= 1'b0;
        end else if (clr) begin
            flag_err <= 1'b0;
        end else if (err_set) begin
            flag_err <= 1'b1;
        end
    end

    // Count advances on the same edge that registers the rise pulse.
    sat_counter #(
        .W (CNT_W)
    ) u_event_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rise_nxt),
        .clr   (clr),
        .count (event_count)
    );

endmodule

// File: tb/tb_cmp_debounce_monitor.sv
// Scoreboard bench: two instances (DEBOUNCE=4/CNT_W=2 and DEBOUNCE=1/CNT_W=8)
// driven in parallel and compared against a streak-based reference model.
module tb_cmp_debounce_monitor;

    typedef struct packed {
        logic       above;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst, clr, in_valid, a_gt_b, a_lt_b, a_eq_b;

    logic       above0, rise0, fall0, err0;
    logic [1:0] cnt0;
    logic       above1, rise1, fall1, err1;
    logic [7:0] cnt1;

    int checks = 0;
    int passed = 0;

    exp_t q0[$];
    exp_t q1[$];

    int lvl[2];
    int streak[2];
    int cnt[2];
    int err[2];
    int deb[2]  = '{4, 1};
    int cmax[2] = '{3, 255};

    always #5 clk = ~clk;

    cmp_debounce_monitor #(.DEBOUNCE(4), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
        .above(above0), .rise(rise0), .fall(fall0),
        .event_count(cnt0), .flag_err(err0)
    );

    cmp_debounce_monitor #(.DEBOUNCE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
        .above(above1), .rise(rise1), .fall(fall1),
        .event_count(cnt1), .flag_err(err1)
    );

    task automatic check(input string name, input exp_t act, input exp_t exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s t=%0t actual above=%b rise=%b fall=%b cnt=%0d err=%b required above=%b rise=%b fall=%b cnt=%0d err=%b",
                      name, $time, act.above, act.rise, act.fall, act.cnt, act.err,
                      exp_v.above, exp_v.rise, exp_v.fall, exp_v.cnt, exp_v.err);
    endtask

    function automatic exp_t act0();
        return {above0, rise0, fall0, {6'b0, cnt0}, err0};
    endfunction

    function automatic exp_t act1();
        return {above1, rise1, fall1, cnt1, err1};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lvl[i] = 0; streak[i] = 0; cnt[i] = 0; err[i] = 0;
        end
    endtask

    // Level flips once DEBOUNCE consecutive legal samples point the other way.
    task automatic model_step(input int i, input logic v, input logic g, input logic l,
                              input logic e, input logic c, output exp_t x);
        logic toward;
        x = '0;
        if (v) begin
            if (int'(g) + int'(l) + int'(e) != 1) begin
                err[i] = 1;
            end else begin
                toward = (lvl[i] != 0) ? l : g;
                if (toward) begin
                    streak[i]++;
                    if (streak[i] == deb[i]) begin
                        streak[i] = 0;
                        if (lvl[i] != 0) x.fall = 1'b1;
                        else             x.rise = 1'b1;
                        lvl[i] = (lvl[i] != 0) ? 0 : 1;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
        end
        if (x.rise && cnt[i] < cmax[i]) cnt[i]++;
        if (c) begin
            cnt[i] = 0;
            err[i] = 0;
        end
        x.above = (lvl[i] != 0);
        x.cnt   = 8'(cnt[i]);
        x.err   = (err[i] != 0);
    endtask

    task automatic step(input logic v, input logic g, input logic l, input logic e, input logic c);
        exp_t x0, x1;
        @(negedge clk);
        in_valid = v; a_gt_b = g; a_lt_b = l; a_eq_b = e; clr = c;
        model_step(0, v, g, l, e, c, x0);
        model_step(1, v, g, l, e, c, x1);
        q0.push_back(x0);
        q1.push_back(x1);
    endtask

    task automatic gt_n(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0);
    endtask

    task automatic lt_n(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 1, 0, 0);
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    // Reset is raised between edges; outputs must clear without waiting for a clock.
    task automatic mid_cycle_reset();
        exp_t zero;
        zero = '0;
        @(negedge clk);
        in_valid = 0; a_gt_b = 0; a_lt_b = 0; a_eq_b = 0; clr = 0;
        #2 rst = 1'b1;
        #1;
        check("async_reset_d4", act0(), zero);
        check("async_reset_d1", act1(), zero);
        #1 rst = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) check("scoreboard_d4", act0(), q0.pop_front());
        if (q1.size() > 0) check("scoreboard_d1", act1(), q1.pop_front());
    end

    initial begin
        logic dir;
        int   r;
        logic [2:0] bad;
        logic [2:0] bad_tab [5];
        bad_tab = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        rst = 1'b1; clr = 0; in_valid = 0; a_gt_b = 0; a_lt_b = 0; a_eq_b = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        idle_n(1);
        gt_n(4);                                 // rise after the 4th gt
        lt_n(4);                                 // back down
        gt_n(3); step(1, 0, 0, 1, 0);            // eq aborts the run
        idle_n(1);
        gt_n(2); idle_n(3); gt_n(2);             // gaps do not break a run
        lt_n(4);
        gt_n(4); lt_n(3); step(1, 1, 0, 0, 0);   // aborted fall
        lt_n(4);
        for (int n = 0; n < 5; n++) begin        // saturate the 2-bit counter
            gt_n(4); lt_n(4);
        end
        gt_n(3); step(1, 1, 0, 0, 1);            // clr on the rise cycle
        lt_n(4);
        gt_n(2); step(1, 1, 1, 0, 0); gt_n(2);   // illegal sample mid-arming
        step(0, 0, 0, 0, 1);                     // clr drops flag_err
        step(1, 0, 1, 1, 1);                     // clr beats illegal sample
        lt_n(4);
        gt_n(2);
        mid_cycle_reset();
        idle_n(2);
        gt_n(4);
        step(1, 0, 0, 1, 0);                     // eq holds the level
        mid_cycle_reset();

        dir = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 15) dir = ~dir;
            if ($urandom_range(0, 499) == 0) begin
                mid_cycle_reset();
            end else if ($urandom_range(0, 99) < 20) begin
                step(0, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 3));
            end else begin
                r = $urandom_range(0, 99);
                if (r < 6) begin
                    bad = bad_tab[$urandom_range(0, 4)];
                    step(1, bad[2], bad[1], bad[0], ($urandom_range(0, 99) < 3));
                end else if (r < 76) begin
                    step(1, dir, ~dir, 0, ($urandom_range(0, 99) < 3));
                end else if (r < 88) begin
                    step(1, 0, 0, 1, ($urandom_range(0, 99) < 3));
                end else begin
                    step(1, ~dir, dir, 0, ($urandom_range(0, 99) < 3));
                end
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL scoreboard_drain actual pending=%0d/%0d required 0/0", q0.size(), q1.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cmp_debounce_monitor.md
Name: cmp_debounce_monitor

Overview:
Sits directly downstream of the team's N-bit magnitude comparator. Consumes its one-hot greater/less/equal flags, one sample at a time under a valid strobe. Debounces the flags into a stable "above threshold" level with hysteresis, emits rise/fall pulses, and counts rising events. Typical use is a sampled value (A) compared against a programmed threshold (B) for alarm generation.

Parameters:
DEBOUNCE, 4, consecutive qualifying valid samples required to change state; legal range 1..255
CNT_W, 8, width of the rising-event counter
RUN_W, derived as $clog2(DEBOUNCE+1), width of the internal run counter; not overridable

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear of event_count and flag_err
in_valid  input  1  comparator flags valid this cycle
a_gt_b  input  1  comparator: A > B
a_lt_b  input  1  comparator: A < B
a_eq_b  input  1  comparator: A == B
above  output  1  debounced level, 1 = A above threshold
rise  output  1  one-cycle pulse on BELOW->ABOVE commit
fall  output  1  one-cycle pulse on ABOVE->BELOW commit
event_count  output  CNT_W  saturating count of rise events
flag_err  output  1  sticky: a valid sample with non-one-hot flags was seen

Behaviour:
- Single clock domain. Reset is asynchronous and active-high (rst); all state and outputs are registered.
- Reset values: state=BELOW, run=0, above=0, rise=0, fall=0, event_count=0, flag_err=0.
- Latency: the sample that completes a debounce run produces the above/rise/fall change on the next clock edge (1 cycle).
- in_valid=0: state, run and outputs hold; rise and fall are 0.
- Sample legality: legal means exactly one of gt/lt/eq is set. An illegal valid sample causes no state or run change and sets flag_err.
- FSM states: BELOW, ARMING, ABOVE, DISARMING. All transitions occur on a legal valid sample only.
  - BELOW: gt -> run=1. If DEBOUNCE==1, go to ABOVE with rise; else go to ARMING. lt or eq -> stay, run=0.
  - ARMING: gt -> run+1. If run+1==DEBOUNCE, go to ABOVE, rise=1, run=0. lt or eq -> go to BELOW, run=0.
  - ABOVE: lt -> run=1. If DEBOUNCE==1, go to BELOW with fall; else go to DISARMING. gt or eq -> stay, run=0.
  - DISARMING: lt -> run+1. If run+1==DEBOUNCE, go to BELOW, fall=1, run=0. gt or eq -> go to ABOVE, run=0.
- Hysteresis: eq never changes the committed level and aborts any pending run.
- above=1 in ABOVE and DISARMING; above=0 in BELOW and ARMING.
- rise and fall are single-cycle pulses and are never asserted together.
- event_count increments on each rise and saturates at 2^CNT_W-1 (no wrap).
- clr: event_count<=0 and flag_err<=0; the FSM is unaffected.
  - clr in the same cycle as a rise: clr wins, count=0; the rise pulse is still emitted.
  - clr in the same cycle as an illegal sample: clr wins, flag_err=0.
- rst mid-run: immediate return to reset values. No pulse is generated by reset.

Decomposition:
- Shared package cmp_pkg: state enum typedef (BELOW, ARMING, ABOVE, DISARMING) and the DEBOUNCE legal-range constants. The package is reused by the comparator bench.
- One sub-module is natural: sat_counter (parameter W, inputs inc/clr, saturating output), used for event_count.
- FSM and run counter stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next edge; state BELOW.
- Debounce rise (DEBOUNCE=4): 4 valid gt samples -> above=1 and rise pulse one cycle after the 4th sample; event_count=1. 3 gt then 1 eq -> above stays 0, no rise.
- Gaps and fall: gt,gt,(in_valid=0 x3),gt,gt -> rise after the 4th valid gt. Then 4 lt -> fall pulse, above=0. lt x3 then gt -> above stays 1.
- Saturation (CNT_W=2): 5 complete rise/fall cycles -> event_count reaches 3 and holds at 3. Apply clr in the cycle of a rise -> count=0 and rise still pulses.
- Illegal flags: valid sample with gt=lt=1 mid-ARMING -> flag_err=1, run preserved, and the next 2 gt complete the rise. clr -> flag_err=0.
- DEBOUNCE=1: single gt -> rise next cycle; single lt -> fall next cycle; eq -> no change.
